// File: rtl/multi_level_ctrl.sv
// multi_level_ctrl
// Multi-channel saturating level controller driven by decoded IR commands.
// Holds NUM_CH levels, a channel selector and a global mute flag. Every
// accepted command (re)starts a sequential double-dabble conversion of the
// selected channel's level. The finished result is shown as a 5-digit display
// word for TIMEOUT_CYCLES clock cycles.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   ir_cmd       decoded IR command code, qualified by ir_valid
//   ir_valid     command strobe, one command per high cycle (no backpressure)
//   display_data registered {char, digit3, hundreds, tens, units}
//   show_level   display word valid; overrides the channel screen
//   mute         global mute flag
//   sel_ch       currently selected channel
//   levels       flat level bus, channel c at [c*LVL_W +: LVL_W]
//   busy         BCD conversion in progress
//
// Handshake: ir_valid has no ready. Every cycle with ir_valid=1 and a
// recognised ir_cmd is accepted and applied at that clock edge.
module multi_level_ctrl #(
  parameter int         NUM_CH         = 4,
  parameter int         LVL_W          = 7,
  parameter int         MAX_LEVEL      = 100,
  parameter int         INIT_LEVEL     = 50,
  parameter int         STEP           = 1,
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter int         CHAR_BASE      = 13,
  parameter int         CHAR_MUTE      = 14,
  parameter logic [7:0] CMD_UP         = 8'h30,
  parameter logic [7:0] CMD_DOWN       = 8'h08,
  parameter logic [7:0] CMD_MUTE       = 8'h10,
  parameter logic [7:0] CMD_SEL        = 8'h20,
  localparam int        CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ir_cmd,
  input  logic                    ir_valid,
  output logic [19:0]             display_data,
  output logic                    show_level,
  output logic                    mute,
  output logic [CH_W-1:0]         sel_ch,
  output logic [NUM_CH*LVL_W-1:0] levels,
  output logic                    busy
);

  localparam int CNT_W = (LVL_W > 1) ? $clog2(LVL_W) : 1;
  localparam int TM_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [LVL_W:0]   MAX_X     = (LVL_W+1)'(MAX_LEVEL);
  localparam logic [LVL_W:0]   STEP_X    = (LVL_W+1)'(STEP);
  localparam logic [LVL_W-1:0] INIT_L    = LVL_W'(INIT_LEVEL);
  localparam logic [TM_W-1:0]  TM_RELOAD = TM_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(LVL_W - 1);
  localparam logic [CH_W-1:0]  SEL_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [3:0]       CHAR_B    = 4'(CHAR_BASE);
  localparam logic [3:0]       CHAR_M    = 4'(CHAR_MUTE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [LVL_W-1:0] lvl [NUM_CH];
  logic [LVL_W-1:0] cur_lvl, up_lvl, down_lvl;
  logic [LVL_W:0]   up_sum;
  logic             is_up, is_down, is_mute, is_sel, accept;
  logic             load_en, shift_en, done_en;
  logic [LVL_W-1:0] bin;
  logic [11:0]      bcd, bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic [TM_W-1:0]  timer;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] add3(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign is_up   = ir_valid && (ir_cmd == CMD_UP);
  assign is_down = ir_valid && (ir_cmd == CMD_DOWN);
  assign is_mute = ir_valid && (ir_cmd == CMD_MUTE);
  assign is_sel  = ir_valid && (ir_cmd == CMD_SEL);
  assign accept  = is_up || is_down || is_mute || is_sel;

  // Saturating arithmetic in LVL_W+1 bits so UP near the top cannot wrap.
  assign cur_lvl  = lvl[sel_ch];
  assign up_sum   = {1'b0, cur_lvl} + STEP_X;
  assign up_lvl   = (up_sum > MAX_X) ? MAX_X[LVL_W-1:0] : up_sum[LVL_W-1:0];
  assign down_lvl = ({1'b0, cur_lvl} >= STEP_X) ? (cur_lvl - STEP_X[LVL_W-1:0])
                                                : '0;
  assign bcd_adj  = add3(bcd);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_levels
    assign levels[c*LVL_W +: LVL_W] = lvl[c];
  end

  assign busy = (state != S_IDLE);

  // Level, mute and channel selector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) lvl[c] <= INIT_L;
      mute   <= 1'b0;
      sel_ch <= '0;
    end else begin
      if (is_up) begin
        lvl[sel_ch] <= up_lvl;
        mute        <= 1'b0;
      end
      if (is_down) begin
        lvl[sel_ch] <= down_lvl;
        mute        <= 1'b0;
      end
      if (is_mute) mute <= ~mute;
      if (is_sel) sel_ch <= (sel_ch == SEL_LAST) ? '0 : sel_ch + CH_W'(1);
    end
  end

  // Conversion FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Conversion FSM: next state and strobes. A new command always wins and
  // restarts at LOAD, which also suppresses a pending DONE write.
  always_comb begin
    state_next = state;
    load_en    = 1'b0;
    shift_en   = 1'b0;
    done_en    = 1'b0;
    if (accept) begin
      state_next = S_LOAD;
    end else begin
      case (state)
        S_IDLE:  state_next = S_IDLE;
        S_LOAD: begin
          load_en    = 1'b1;
          state_next = S_SHIFT;
        end
        S_SHIFT: begin
          shift_en = 1'b1;
          if (cnt == CNT_LAST) state_next = S_DONE;
        end
        S_DONE: begin
          done_en    = 1'b1;
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Double-dabble datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (load_en) begin
      bin <= cur_lvl;
      bcd <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      bcd <= {bcd_adj[10:0], bin[LVL_W-1]};
      bin <= bin << 1;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Display word and hold timer. A command reloads the timer so the word
  // cannot blank while a restarted conversion is still running.
  always_ff @(posedge clk) begin
    if (rst) begin
      display_data <= '0;
      show_level   <= 1'b0;
      timer        <= '0;
    end else if (accept) begin
      timer <= TM_RELOAD;
    end else if (done_en) begin
      display_data <= {CHAR_B + 4'(sel_ch), (mute ? CHAR_M : 4'd0), bcd};
      show_level   <= 1'b1;
      timer        <= TM_RELOAD;
    end else if (show_level) begin
      if (timer == '0) begin
        show_level   <= 1'b0;
        display_data <= '0;
      end else begin
        timer <= timer - TM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_level_ctrl.sv
// Testbench for multi_level_ctrl: directed vector table plus hand-written
// sequences for latency, timeout, saturation, abort and reset corner cases.
module tb_multi_level_ctrl;

  localparam int NUM_CH  = 4;
  localparam int LVL_W   = 7;
  localparam int TIMEOUT = 20;

  localparam logic [7:0] UP   = 8'h30;
  localparam logic [7:0] DOWN = 8'h08;
  localparam logic [7:0] MUTE = 8'h10;
  localparam logic [7:0] SEL  = 8'h20;
  localparam logic [7:0] BAD  = 8'hFF;

  logic                    clk;
  logic                    rst;
  logic [7:0]              ir_cmd;
  logic                    ir_valid;
  logic [19:0]             display_data;
  logic                    show_level;
  logic                    mute;
  logic [1:0]              sel_ch;
  logic [NUM_CH*LVL_W-1:0] levels;
  logic                    busy;

  int checks   = 0;
  int failures = 0;

  multi_level_ctrl #(
    .NUM_CH(NUM_CH), .LVL_W(LVL_W), .MAX_LEVEL(100), .INIT_LEVEL(50),
    .STEP(1), .TIMEOUT_CYCLES(TIMEOUT), .CHAR_BASE(12), .CHAR_MUTE(14)
  ) dut (
    .clk(clk), .rst(rst), .ir_cmd(ir_cmd), .ir_valid(ir_valid),
    .display_data(display_data), .show_level(show_level), .mute(mute),
    .sel_ch(sel_ch), .levels(levels), .busy(busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change and outputs are sampled 1 ns after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    ir_cmd   = c;
    ir_valid = 1'b1;
    step();
    ir_valid = 1'b0;
    ir_cmd   = 8'h00;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*LVL_W-1:0] pack4(input int l0, input int l1,
                                                    input int l2, input int l3);
    return {7'(l3), 7'(l2), 7'(l1), 7'(l0)};
  endfunction

  typedef struct {
    logic [7:0]  cmd;
    int          l0, l1, l2, l3;
    int          sel;
    logic        mute;
    logic [19:0] disp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int exp_l0;
    vecs[0]  = '{MUTE, 51, 50, 50, 50, 0, 1'b1, 20'hCE051};
    vecs[1]  = '{UP,   52, 50, 50, 50, 0, 1'b0, 20'hC0052};
    vecs[2]  = '{DOWN, 51, 50, 50, 50, 0, 1'b0, 20'hC0051};
    vecs[3]  = '{SEL,  51, 50, 50, 50, 1, 1'b0, 20'hD0050};
    vecs[4]  = '{UP,   51, 51, 50, 50, 1, 1'b0, 20'hD0051};
    vecs[5]  = '{SEL,  51, 51, 50, 50, 2, 1'b0, 20'hE0050};
    vecs[6]  = '{MUTE, 51, 51, 50, 50, 2, 1'b1, 20'hEE050};
    vecs[7]  = '{SEL,  51, 51, 50, 50, 3, 1'b1, 20'hFE050};
    vecs[8]  = '{DOWN, 51, 51, 50, 49, 3, 1'b0, 20'hF0049};
    vecs[9]  = '{SEL,  51, 51, 50, 49, 0, 1'b0, 20'hC0051};
    vecs[10] = '{BAD,  51, 51, 50, 49, 0, 1'b0, 20'hC0051};
    vecs[11] = '{MUTE, 51, 51, 50, 49, 0, 1'b1, 20'hCE051};
    vecs[12] = '{MUTE, 51, 51, 50, 49, 0, 1'b0, 20'hC0051};

    rst = 1'b1; ir_valid = 1'b0; ir_cmd = 8'h00;
    wait_cycles(2);
    rst = 1'b0;

    // Reset state
    check("rst_display", 32'(display_data), 32'h0);
    check("rst_show", 32'(show_level), 32'h0);
    check("rst_mute", 32'(mute), 32'h0);
    check("rst_sel", 32'(sel_ch), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_levels", 32'(levels), 32'(pack4(50, 50, 50, 50)));

    // First UP: level visible after E, display after E+9
    send_cmd(UP);
    check("up_level", 32'(levels), 32'(pack4(51, 50, 50, 50)));
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k < 9) begin
        check("lat_busy", 32'(busy), 32'h1);
        check("lat_show", 32'(show_level), 32'h0);
        check("lat_disp_hold", 32'(display_data), 32'h0);
      end else begin
        check("lat_busy_end", 32'(busy), 32'h0);
        check("lat_show_end", 32'(show_level), 32'h1);
        check("lat_disp", 32'(display_data), 32'hC0051);
      end
    end

    // Timeout: show_level high exactly TIMEOUT cycles after DONE
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      check("to_show_hold", 32'(show_level), 32'h1);
    end
    step();
    check("to_show_clear", 32'(show_level), 32'h0);
    check("to_disp_clear", 32'(display_data), 32'h0);

    // Table-driven vectors, one spaced command each
    for (int v = 0; v < 13; v++) begin
      send_cmd(vecs[v].cmd);
      wait_cycles(9);
      check("vec_levels", 32'(levels),
            32'(pack4(vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3)));
      check("vec_sel", 32'(sel_ch), 32'(vecs[v].sel));
      check("vec_mute", 32'(mute), 32'(vecs[v].mute));
      check("vec_disp", 32'(display_data), 32'(vecs[v].disp));
      check("vec_show", 32'(show_level), 32'h1);
      check("vec_busy", 32'(busy), 32'h0);
    end

    // Saturation at MAX_LEVEL, then floor at 0
    exp_l0 = 51;
    for (int i = 0; i < 60; i++) begin
      send_cmd(UP);
      wait_cycles(9);
      exp_l0 = (exp_l0 + 1 > 100) ? 100 : exp_l0 + 1;
      check("sat_up_level", 32'(levels[6:0]), 32'(exp_l0));
    end
    check("sat_up_disp", 32'(display_data), 32'hC0100);
    for (int i = 0; i < 101; i++) begin
      send_cmd(DOWN);
      wait_cycles(9);
      exp_l0 = (exp_l0 >= 1) ? exp_l0 - 1 : 0;
      check("sat_dn_level", 32'(levels[6:0]), 32'(exp_l0));
    end
    check("sat_dn_disp", 32'(display_data), 32'hC0000);
    check("sat_others", 32'(levels), 32'(pack4(0, 51, 50, 49)));

    // Back-to-back UPs arriving mid-conversion: one final display only
    send_cmd(UP);
    wait_cycles(3);
    ir_cmd = UP; ir_valid = 1'b1;
    wait_cycles(3);
    ir_valid = 1'b0; ir_cmd = 8'h00;
    check("b2b_level", 32'(levels[6:0]), 32'd4);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k < 9) check("b2b_disp_hold", 32'(display_data), 32'hC0000);
      else       check("b2b_disp", 32'(display_data), 32'hC0004);
    end
    check("b2b_show", 32'(show_level), 32'h1);

    // Command at cycle 15 of the show window opens a fresh window
    wait_cycles(14);
    send_cmd(UP);
    for (int k = 16; k <= 43; k++) begin
      step();
      check("refresh_show", 32'(show_level), 32'h1);
      if (k == 24) check("refresh_disp", 32'(display_data), 32'hC0005);
    end
    step();
    check("refresh_show_clear", 32'(show_level), 32'h0);
    check("refresh_disp_clear", 32'(display_data), 32'h0);

    // Reset during SHIFT aborts with no display update
    send_cmd(SEL);
    send_cmd(UP);
    send_cmd(MUTE);
    wait_cycles(3);
    check("pre_rst_busy", 32'(busy), 32'h1);
    check("pre_rst_mute", 32'(mute), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_display", 32'(display_data), 32'h0);
    check("mid_rst_show", 32'(show_level), 32'h0);
    check("mid_rst_mute", 32'(mute), 32'h0);
    check("mid_rst_sel", 32'(sel_ch), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_levels", 32'(levels), 32'(pack4(50, 50, 50, 50)));
    wait_cycles(12);
    check("post_rst_display", 32'(display_data), 32'h0);
    check("post_rst_show", 32'(show_level), 32'h0);

    // Unrecognised code changes nothing
    send_cmd(BAD);
    check("bad_busy", 32'(busy), 32'h0);
    check("bad_levels", 32'(levels), 32'(pack4(50, 50, 50, 50)));
    check("bad_sel", 32'(sel_ch), 32'h0);
    check("bad_mute", 32'(mute), 32'h0);
    wait_cycles(10);
    check("bad_display", 32'(display_data), 32'h0);
    check("bad_show", 32'(show_level), 32'h0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
